// File: rtl/vga_pkg.sv
// Shared VGA timing constants (640x480@60), counter width and select-FSM encoding.
// Also provides the half-open interval test used for all sync/blank decodes.
package vga_pkg;

    localparam int CNT_W    = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    typedef enum logic {
        SEL_IDLE = 1'b0,
        SEL_PEND = 1'b1
    } sel_state_t;

    // lo <= v < hi, evaluated in int so no bound is truncated to the counter width
    function automatic logic in_span(input logic [CNT_W-1:0] v, input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Timing/strobe bundle from vga_timing_ctrl to the downstream video_gen stage.
interface vga_timing_ctrl_if;
    import vga_pkg::*;

    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic             hsync;
    logic             vsync;
    logic             blank_b;
    logic             sync_b;
    logic             vga_clk;
    logic             px_en;
    logic             frame_start;
    logic             is_output_img;

    modport master (
        output x, y, hsync, vsync, blank_b, sync_b, vga_clk, px_en, frame_start, is_output_img
    );

    modport slave (
        input x, y, hsync, vsync, blank_b, sync_b, vga_clk, px_en, frame_start, is_output_img
    );

endinterface

// File: rtl/btn_debounce.sv
// Accepts a new button level only after DEB_CYCLES consecutive samples that differ from the current one.
// q_rise is a one-clock pulse when the accepted level goes 0 -> 1.
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic d_sync,
    output logic q_level,
    output logic q_rise
);

    localparam int              DEB_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEB_CYCLES - 1);

    logic [DEB_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt     <= '0;
            q_level <= 1'b0;
            q_rise  <= 1'b0;
        end else begin
            q_rise <= 1'b0;
            if (d_sync == q_level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                q_level <= d_sync;
                q_rise  <= d_sync;
            end else begin
                cnt <= cnt + DEB_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel divider, x/y raster counters, registered sync/blank strobes,
// and the frame-aligned original/processed image select driven by a debounced button.
module vga_timing_ctrl #(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = vga_pkg::H_ACTIVE,
    parameter int H_FP       = vga_pkg::H_FP,
    parameter int H_SYNC     = vga_pkg::H_SYNC,
    parameter int H_BP       = vga_pkg::H_BP,
    parameter int V_ACTIVE   = vga_pkg::V_ACTIVE,
    parameter int V_FP       = vga_pkg::V_FP,
    parameter int V_SYNC     = vga_pkg::V_SYNC,
    parameter int V_BP       = vga_pkg::V_BP,
    parameter int DEB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_sel,
    vga_timing_ctrl_if.master vif
);
    import vga_pkg::*;

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO = H_ACTIVE + H_FP;
    localparam int HS_HI = HS_LO + H_SYNC;
    localparam int VS_LO = V_ACTIVE + V_FP;
    localparam int VS_HI = VS_LO + V_SYNC;

    localparam int               DIV_W    = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOT - 1);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [CNT_W-1:0] x_q, y_q, x_nxt, y_nxt;
    logic             px_q, fs_q, hs_q, vs_q, blank_q, vclk_q;
    logic             btn_s1, btn_s2, btn_rise, btn_level_unused;
    sel_state_t       sel_q, sel_nxt;
    logic             img_q, img_nxt;

    always_comb begin
        div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
        x_nxt   = x_q;
        y_nxt   = y_q;
        if (px_q) begin
            if (x_q == X_LAST) begin
                x_nxt = '0;
                y_nxt = (y_q == Y_LAST) ? '0 : y_q + CNT_W'(1);
            end else begin
                x_nxt = x_q + CNT_W'(1);
            end
        end
    end

    // Strobes are decoded from the next-count values so they line up with x/y in the same cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            x_q     <= '0;
            y_q     <= '0;
            px_q    <= 1'b0;
            fs_q    <= 1'b0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            vclk_q  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            px_q    <= (div_nxt == DIV_LAST);
            fs_q    <= (div_nxt == DIV_LAST) && (x_nxt == '0) && (y_nxt == '0);
            hs_q    <= !in_span(x_nxt, HS_LO, HS_HI);
            vs_q    <= !in_span(y_nxt, VS_LO, VS_HI);
            blank_q <= in_span(x_nxt, 0, H_ACTIVE) && in_span(y_nxt, 0, V_ACTIVE);
            vclk_q  <= (div_nxt >= DIV_HALF);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_sel;
            btn_s2 <= btn_s1;
        end
    end

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst    (rst),
        .d_sync (btn_s2),
        .q_level(btn_level_unused),
        .q_rise (btn_rise)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_q <= SEL_IDLE;
            img_q <= 1'b0;
        end else begin
            sel_q <= sel_nxt;
            img_q <= img_nxt;
        end
    end

    // A press landing on the frame_start cycle itself re-arms and waits for the next frame
    always_comb begin
        sel_nxt = sel_q;
        img_nxt = img_q;
        case (sel_q)
            SEL_IDLE: begin
                if (btn_rise) sel_nxt = SEL_PEND;
            end
            SEL_PEND: begin
                if (fs_q) begin
                    img_nxt = ~img_q;
                    sel_nxt = btn_rise ? SEL_PEND : SEL_IDLE;
                end
            end
            default: sel_nxt = SEL_IDLE;
        endcase
    end

    assign vif.x             = x_q;
    assign vif.y             = y_q;
    assign vif.hsync         = hs_q;
    assign vif.vsync         = vs_q;
    assign vif.blank_b       = blank_q;
    assign vif.sync_b        = 1'b0;
    assign vif.vga_clk       = vclk_q;
    assign vif.px_en         = px_q;
    assign vif.frame_start   = fs_q;
    assign vif.is_output_img = img_q;

endmodule
